mem_req_arbiter: RTL and testbench

//   Shares the single byte-serial memory controller between the instruction fetcher and the load/store unit.

---
 rtl/mem_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Arbitrates the byte-serial memory controller between instruction fetch and load/store.
// One request slot per requester; completions are routed back and squashed reads are dropped on flush.
module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ok,
    output logic [DATA_W-1:0] if_inst,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_size,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ok,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mc_req,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [2:0]        mc_size,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS, DRAIN} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t state, state_nxt;

    logic              if_vld, ls_vld, ls_wr_s;
    logic [ADDR_W-1:0] if_addr_s, ls_addr_s;
    logic [2:0]        ls_size_s;
    logic [DATA_W-1:0] ls_wdata_s;
    logic [3:0]        starve_cnt;

    logic if_fin, ls_fin, free, grant_if, grant_ls;
    logic if_cap, ls_cap, ls_flush_clr;

    always_comb begin
        if_fin       = 1'b0;
        ls_fin       = 1'b0;
        free         = 1'b0;
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        ls_flush_clr = 1'b0;
        if_cap       = 1'b0;
        ls_cap       = 1'b0;
        state_nxt    = state;

        if_fin = (state == BUSY_IF) && mc_done && !flush;
        // a store in flight survives a flush; only loads are squashed
        ls_fin = (state == BUSY_LS) && mc_done && !(flush && !mc_wr);
        // completion and the next issue share one edge, so the arbiter never idles a cycle
        free   = !flush && ((state == IDLE) || if_fin || ls_fin);

        grant_ls = free && ls_vld && !(if_vld && (starve_cnt == LIMIT));
        grant_if = free && if_vld && !grant_ls;

        ls_flush_clr = flush && !ls_wr_s;
        if_cap       = if_req && (!if_vld || flush);
        ls_cap       = ls_req && (!ls_vld || ls_flush_clr);

        case (state)
            BUSY_IF: begin
                if (flush)        state_nxt = mc_done ? IDLE : DRAIN;
                else if (mc_done) state_nxt = IDLE;
            end
            BUSY_LS: begin
                if (flush && !mc_wr) state_nxt = mc_done ? IDLE : DRAIN;
                else if (mc_done)    state_nxt = IDLE;
            end
            DRAIN: begin
                if (mc_done) state_nxt = IDLE;
            end
            default: state_nxt = state;
        endcase

        if (grant_if)      state_nxt = BUSY_IF;
        else if (grant_ls) state_nxt = BUSY_LS;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            if_vld     <= 1'b0;
            if_addr_s  <= '0;
            ls_vld     <= 1'b0;
            ls_wr_s    <= 1'b0;
            ls_addr_s  <= '0;
            ls_size_s  <= '0;
            ls_wdata_s <= '0;
            starve_cnt <= '0;
            mc_req     <= 1'b0;
            mc_wr      <= 1'b0;
            mc_addr    <= '0;
            mc_size    <= '0;
            mc_wdata   <= '0;
            if_ok      <= 1'b0;
            if_inst    <= '0;
            ls_ok      <= 1'b0;
            ls_rdata   <= '0;
        end else if (rdy) begin
            state <= state_nxt;

            if (if_cap) begin
                if_vld    <= 1'b1;
                if_addr_s <= if_addr;
            end else if (grant_if || flush) begin
                if_vld <= 1'b0;
            end

            if (ls_cap) begin
                ls_vld     <= 1'b1;
                ls_wr_s    <= ls_wr;
                ls_addr_s  <= ls_addr;
                ls_size_s  <= ls_size;
                ls_wdata_s <= ls_wdata;
            end else if (grant_ls || ls_flush_clr) begin
                ls_vld <= 1'b0;
            end

            if (grant_if)
                starve_cnt <= '0;
            else if (grant_ls && if_vld && (starve_cnt != LIMIT))
                starve_cnt <= starve_cnt + 4'd1;

            mc_req <= grant_if || grant_ls;
            if (grant_if) begin
                mc_wr    <= 1'b0;
                mc_addr  <= if_addr_s;
                mc_size  <= 3'd4;
                mc_wdata <= '0;
            end else if (grant_ls) begin
                mc_wr    <= ls_wr_s;
                mc_addr  <= ls_addr_s;
                mc_size  <= ls_size_s;
                mc_wdata <= ls_wdata_s;
            end

            if_ok <= if_fin;
            if (if_fin) if_inst <= mc_rdata;
            ls_ok <= ls_fin;
            if (ls_fin) ls_rdata <= mc_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy)
            assert (!(state == IDLE && mc_done))
            else $error("mem_req_arbiter: mc_done received while IDLE");
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: the bench plays the memory controller and
// checks issue order, routing, starvation, flush, freeze and reset behaviour.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        if_req, if_ok;
    logic [31:0] if_addr, if_inst;
    logic        ls_req, ls_wr, ls_ok;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [2:0]  ls_size;
    logic        mc_req, mc_wr, mc_done;
    logic [31:0] mc_addr, mc_wdata, mc_rdata;
    logic [2:0]  mc_size;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] last_inst;

    mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_ok(if_ok), .if_inst(if_inst),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_ok(ls_ok), .ls_rdata(ls_rdata),
        .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_size(mc_size),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mc_finish(input logic [31:0] d);
        mc_done  = 1'b1;
        mc_rdata = d;
        tick();
        mc_done  = 1'b0;
    endtask

    task automatic send_if(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        tick();
        if_req  = 1'b0;
    endtask

    task automatic send_ls(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        ls_req   = 1'b1;
        ls_wr    = w;
        ls_addr  = a;
        ls_size  = s;
        ls_wdata = d;
        tick();
        ls_req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_size = '0; ls_wdata = '0;
        mc_done = 1'b0; mc_rdata = '0;
        tick(); tick();
        chk("rst_ctl", {27'd0, mc_req, mc_wr, if_ok, ls_ok, 1'b0}, 32'd0);
        chk("rst_addr", mc_addr, 32'd0);
        chk("rst_size", {29'd0, mc_size}, 32'd0);
        rst = 1'b1;
        tick();

        // T1 single fetch
        send_if(32'h100);
        chk("t1_no_early_req", {31'd0, mc_req}, 32'd0);
        tick();
        chk("t1_mc_req", {31'd0, mc_req}, 32'd1);
        chk("t1_mc_addr", mc_addr, 32'h100);
        chk("t1_mc_size", {29'd0, mc_size}, 32'd4);
        chk("t1_mc_wr", {31'd0, mc_wr}, 32'd0);
        tick();
        chk("t1_req_pulse", {31'd0, mc_req}, 32'd0);
        tick(); tick(); tick();
        mc_finish(32'h00500093);
        chk("t1_if_ok", {31'd0, if_ok}, 32'd1);
        chk("t1_if_inst", if_inst, 32'h00500093);
        tick();
        chk("t1_ok_pulse", {31'd0, if_ok}, 32'd0);
        chk("t1_inst_hold", if_inst, 32'h00500093);

        // T2 collision: load wins, fetch issues alongside ls_ok
        if_req = 1'b1; if_addr = 32'h400;
        send_ls(1'b0, 32'h2000, 3'd4, 32'd0);
        if_req = 1'b0;
        tick();
        chk("t2_ls_first", mc_addr, 32'h2000);
        chk("t2_ls_req", {31'd0, mc_req}, 32'd1);
        tick();
        mc_finish(32'h11223344);
        chk("t2_ls_ok", {31'd0, ls_ok}, 32'd1);
        chk("t2_ls_rdata", ls_rdata, 32'h11223344);
        chk("t2_if_issue_same", {31'd0, mc_req}, 32'd1);
        chk("t2_if_addr", mc_addr, 32'h400);
        tick();
        mc_finish(32'h0000AAAA);
        chk("t2_if_ok", {31'd0, if_ok}, 32'd1);
        chk("t2_if_inst", if_inst, 32'h0000AAAA);

        // T3 starvation: four LS grants, then the waiting fetch
        if_req = 1'b1; if_addr = 32'h500;
        send_ls(1'b0, 32'h600, 3'd4, 32'd0);
        if_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_ls_grant%0d", i), mc_addr, 32'h600 + 32'(4 * i));
            chk($sformatf("t3_ls_req%0d", i), {31'd0, mc_req}, 32'd1);
            send_ls(1'b0, 32'h600 + 32'(4 * (i + 1)), 3'd4, 32'd0);
            mc_finish(32'h100 + 32'(i));
            chk($sformatf("t3_ls_ok%0d", i), {31'd0, ls_ok}, 32'd1);
        end
        chk("t3_if_grant", mc_addr, 32'h500);
        chk("t3_if_req", {31'd0, mc_req}, 32'd1);
        chk("t3_if_size", {29'd0, mc_size}, 32'd4);
        tick();
        mc_finish(32'h0000BBBB);
        last_inst = 32'h0000BBBB;
        chk("t3_if_ok", {31'd0, if_ok}, 32'd1);
        chk("t3_last_ls", mc_addr, 32'h610);
        chk("t3_starve_zero", {28'd0, dut.starve_cnt}, 32'd0);
        tick();
        mc_finish(32'h0);
        chk("t3_last_ls_ok", {31'd0, ls_ok}, 32'd1);

        // T4 flush during fetch, with a post-flush request
        send_if(32'h700);
        tick();
        chk("t4_issue", mc_addr, 32'h700);
        flush = 1'b1;
        send_if(32'h200);
        flush = 1'b0;
        chk("t4_drain_no_issue", {31'd0, mc_req}, 32'd0);
        tick();
        mc_finish(32'hDEADBEEF);
        chk("t4_no_if_ok", {31'd0, if_ok}, 32'd0);
        chk("t4_inst_kept", if_inst, last_inst);
        chk("t4_idle_first", {31'd0, mc_req}, 32'd0);
        tick();
        chk("t4_post_flush_req", {31'd0, mc_req}, 32'd1);
        chk("t4_post_flush_addr", mc_addr, 32'h200);
        tick();
        mc_finish(32'h00000013);
        chk("t4_post_if_ok", {31'd0, if_ok}, 32'd1);
        chk("t4_post_if_inst", if_inst, 32'h00000013);

        // flush and mc_done together: result dropped, straight back to IDLE
        send_if(32'h800);
        tick();
        flush = 1'b1;
        mc_finish(32'h0BADF00D);
        flush = 1'b0;
        chk("t4b_no_if_ok", {31'd0, if_ok}, 32'd0);
        chk("t4b_inst_kept", if_inst, 32'h00000013);
        send_if(32'h900);
        tick();
        chk("t4b_idle_issue", {31'd0, mc_req}, 32'd1);
        chk("t4b_idle_addr", mc_addr, 32'h900);
        tick();
        mc_finish(32'h77);
        chk("t4b_if_ok", {31'd0, if_ok}, 32'd1);

        // T5 flush during a store: store still completes
        send_ls(1'b1, 32'h3000, 3'd1, 32'h000000AB);
        tick();
        chk("t5_mc_wr", {31'd0, mc_wr}, 32'd1);
        chk("t5_mc_addr", mc_addr, 32'h3000);
        chk("t5_mc_size", {29'd0, mc_size}, 32'd1);
        chk("t5_mc_wdata", mc_wdata, 32'h000000AB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mc_finish(32'h0);
        chk("t5_ls_ok", {31'd0, ls_ok}, 32'd1);

        // T6 freeze mid-BUSY_LS: mc_done during freeze is not sampled
        send_ls(1'b0, 32'h4000, 3'd2, 32'd0);
        tick();
        chk("t6_issue", {31'd0, mc_req}, 32'd1);
        rdy = 1'b0;
        mc_done = 1'b1; mc_rdata = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_frz_req%0d", i), {31'd0, mc_req}, 32'd1);
            chk($sformatf("t6_frz_ok%0d", i), {31'd0, ls_ok}, 32'd0);
            chk($sformatf("t6_frz_addr%0d", i), mc_addr, 32'h4000);
        end
        mc_done = 1'b0;
        rdy = 1'b1;
        tick();
        chk("t6_req_drop", {31'd0, mc_req}, 32'd0);
        chk("t6_still_busy", {31'd0, ls_ok}, 32'd0);
        mc_finish(32'h55);
        chk("t6_ls_ok", {31'd0, ls_ok}, 32'd1);
        chk("t6_ls_rdata", ls_rdata, 32'h55);
        rdy = 1'b0;
        tick();
        chk("t6_ok_held", {31'd0, ls_ok}, 32'd1);
        rdy = 1'b1;
        tick();
        chk("t6_ok_clear", {31'd0, ls_ok}, 32'd0);

        // reset in the middle of an access
        send_ls(1'b0, 32'h5000, 3'd4, 32'd0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_ctl", {28'd0, mc_req, mc_wr, if_ok, ls_ok}, 32'd0);
        chk("t6_rst_addr", mc_addr, 32'd0);
        chk("t6_rst_size", {29'd0, mc_size}, 32'd0);
        chk("t6_rst_inst", if_inst, 32'd0);
        chk("t6_rst_rdata", ls_rdata, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("t6_post_rst_ok", {30'd0, if_ok, ls_ok}, 32'd0);
        chk("t6_post_rst_req", {31'd0, mc_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
